// File: rtl/sum_acc.sv
`default_nettype none
// ============================================================================
// Module   : sum_acc
// Brief    : Burst accumulator for {c_out, sum} adder results. Sums COUNT
//            words into an exact-width total and counts carried-out words.
// Revision : 1.0 - initial release
// ============================================================================
module sum_acc #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4,
    localparam int ACC_W = WIDTH + 1 + $clog2(COUNT),
    localparam int CNT_W = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_c_out,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [CNT_W-1:0] out_carries
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [CNT_W-1:0]   carries_q, carries_d;

    logic [ACC_W-1:0]   w_word;
    logic [CNT_W-1:0]   w_carry;

    assign w_word  = {{(ACC_W-WIDTH-1){1'b0}}, in_c_out, in_sum};
    assign w_carry = {{(CNT_W-1){1'b0}}, in_c_out};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        words_d   = words_q;
        carries_d = carries_q;
        case (state_q)
            ST_IDLE: begin
                acc_d     = '0;
                words_d   = '0;
                carries_d = '0;
                if (!flush && in_valid) begin
                    acc_d     = w_word;
                    words_d   = CNT_W'(1);
                    carries_d = w_carry;
                    state_d   = ST_ACC;
                end
            end
            ST_ACC: begin
                // Flush wins over a word presented in the same cycle.
                if (flush) begin
                    acc_d     = '0;
                    words_d   = '0;
                    carries_d = '0;
                    state_d   = ST_IDLE;
                end else if (in_valid) begin
                    acc_d     = acc_q + w_word;
                    words_d   = words_q + CNT_W'(1);
                    carries_d = carries_q + w_carry;
                    if (words_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    acc_d     = '0;
                    words_d   = '0;
                    carries_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                acc_d     = '0;
                words_d   = '0;
                carries_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            words_q   <= '0;
            carries_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            words_q   <= words_d;
            carries_q <= carries_d;
        end
    end

    assign in_ready    = (state_q != ST_DONE);
    assign out_valid   = (state_q == ST_DONE);
    assign out_total   = acc_q;
    assign out_carries = carries_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_acc
// Brief    : Directed self-checking bench for sum_acc with default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_sum;
    logic       in_c_out;
    logic       in_ready;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_total;
    logic [2:0] out_carries;

    int n_tests = 0;
    int n_fail  = 0;

    sum_acc #(.WIDTH(4), .COUNT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sum      (in_sum),
        .in_c_out    (in_c_out),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_total   (out_total),
        .out_carries (out_carries)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic c, input logic [3:0] s);
        in_valid = 1'b1;
        in_c_out = c;
        in_sum   = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_out(input string tag, input int vld, input int tot, input int car);
        chk({tag, ".out_valid"},   int'(out_valid),   vld);
        chk({tag, ".out_total"},   int'(out_total),   tot);
        chk({tag, ".out_carries"}, int'(out_carries), car);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 4'd5;
        in_c_out  = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset held two cycles with in_valid asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst.in_ready", int'(in_ready), 1);
            chk_out("rst", 0, 0, 0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();

        // Maximum burst, back to back
        in_valid = 1'b1; in_c_out = 1'b1; in_sum = 4'hF;
        idle(3);
        chk("max.early_valid", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        chk_out("max", 1, 124, 4);
        chk("max.in_ready_done", int'(in_ready), 0);
        tick();
        chk("max.idle_valid", int'(out_valid), 0);
        chk("max.idle_ready", int'(in_ready), 1);

        // Bubbles between words
        word(1'b0, 4'd3); idle(2);
        word(1'b0, 4'd0); idle(2);
        word(1'b0, 4'd7); idle(2);
        chk("bub.early_valid", int'(out_valid), 0);
        word(1'b0, 4'd1);
        chk_out("bub", 1, 11, 0);
        tick();

        // Back-pressure: result held, extra words ignored
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) word(1'b1, 4'd0);
        in_valid = 1'b1; in_c_out = 1'b0; in_sum = 4'd9;
        for (int i = 0; i < 5; i++) begin
            chk_out("bp", 1, 64, 4);
            chk("bp.in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid  = 1'b0;
        chk_out("bp.last", 1, 64, 4);
        out_ready = 1'b1;
        tick();
        chk("bp.after_valid", int'(out_valid), 0);
        chk("bp.after_ready", int'(in_ready), 1);

        // Flush mid-burst drops the concurrent word
        word(1'b0, 4'd5);
        word(1'b0, 4'd6);
        flush = 1'b1;
        word(1'b0, 4'd7);
        flush = 1'b0;
        chk("fl.in_ready", int'(in_ready), 1);
        word(1'b0, 4'd1);
        word(1'b0, 4'd2);
        word(1'b0, 4'd3);
        chk("fl.early_valid", int'(out_valid), 0);
        word(1'b0, 4'd4);
        chk_out("fl", 1, 10, 0);
        tick();

        // Flush in DONE is ignored
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) word(1'b0, 4'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_out("fldone", 1, 8, 0);
        out_ready = 1'b1;
        tick();

        // Reset while in DONE
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) word(1'b1, 4'd1);
        chk_out("rdone.pre", 1, 68, 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_out("rdone", 0, 0, 0);
        chk("rdone.in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) word(1'b0, 4'd2);
        chk_out("rdone.next", 1, 8, 0);
        tick();

        // Reset after three accepted words
        for (int i = 0; i < 3; i++) word(1'b1, 4'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_out("racc", 0, 0, 0);
        for (int i = 0; i < 3; i++) word(1'b0, 4'd2);
        chk("racc.early_valid", int'(out_valid), 0);
        word(1'b0, 4'd2);
        chk_out("racc.next", 1, 8, 0);
        tick();
        chk("racc.idle", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
